// File: rtl/ram_arbiter.sv
// Two-port req/ack arbiter that sequences a single-port RAM between
// instruction fetch (read-only) and data load/store. One transaction is in
// flight at a time: IDLE grants, ISSUE strobes the RAM, WAIT covers the read
// latency, and DONE pulses the owner's ack.
module ram_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int PRIO_DATA = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_adr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Transaction captured at grant; the RAM side is driven only from this,
  // so requester-side changes after the grant have no effect.
  typedef struct packed {
    logic              own;   // 0 = fetch, 1 = data
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wdata;
  } xfer_t;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;
  localparam int   CW     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT - 1);

  state_t        state, nxt;
  xfer_t         cur;
  logic [CW-1:0] cnt;
  logic          last_gnt;
  logic          grant;
  logic          gnt_own;
  logic          cap;

  // Next-state, grant decision and strobes/acks decoded from the state.
  always_comb begin
    nxt       = state;
    grant     = 1'b0;
    gnt_own   = PORT_F;
    ram_read  = 1'b0;
    ram_write = 1'b0;
    f_ack     = 1'b0;
    d_ack     = 1'b0;
    cap       = 1'b0;
    unique case (state)
      IDLE: begin
        if (f_req || d_req) begin
          grant = 1'b1;
          if (f_req && d_req)
            gnt_own = (PRIO_DATA != 0) ? PORT_D : ~last_gnt;
          else
            gnt_own = d_req;
          nxt = ISSUE;
        end
      end
      ISSUE: begin
        ram_read  = ~cur.we;
        ram_write = cur.we;
        nxt       = cur.we ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt == CNT_LAST) begin
          cap = 1'b1;
          nxt = DONE;
        end
      end
      DONE: begin
        f_ack = (cur.own == PORT_F);
        d_ack = (cur.own == PORT_D);
        nxt   = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // State register; reset drops every decoded strobe and ack at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Latch the granted transaction and remember who was served last.
  // last_gnt resets to data so fetch wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= '0;
      last_gnt <= PORT_D;
    end else begin
      if (grant)
        cur <= '{own:   gnt_own,
                 we:    gnt_own & d_we,
                 adr:   gnt_own ? d_adr : f_adr,
                 wdata: d_wdata};
      if (state == DONE)
        last_gnt <= cur.own;
    end
  end

  // Read-latency counter, only counts while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (state == WAIT)  cnt <= cnt + CW'(1);
    else                     cnt <= '0;
  end

  // Capture RAM data into the owner's register; the other port keeps its word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_rdata <= '0;
      d_rdata <= '0;
    end else if (cap) begin
      if (cur.own == PORT_D) d_rdata <= ram_out;
      else                   f_rdata <= ram_out;
    end
  end

  assign ram_adr   = cur.adr;
  assign ram_wdata = cur.wdata;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: three instances (RD_LAT=1 round-robin, RD_LAT=1
// data-priority, RD_LAT=3 round-robin), each with a RAM model and a
// timer-based transaction model checked every cycle, plus directed vectors
// with hand-computed cycle numbers and data. Cycle 1 is the idle cycle in
// which a fresh request is first presented.
module tb_ram_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       rst_n = '0, f_req = '0, d_req = '0, d_we = '0;
  logic [N-1:0][7:0]  f_adr = '0, d_adr = '0;
  logic [N-1:0][15:0] d_wdata = '0;
  logic [N-1:0]       f_ack, d_ack, ram_read, ram_write, busy;
  logic [N-1:0][7:0]  ram_adr;
  logic [N-1:0][15:0] f_rdata, d_rdata, ram_wdata, ram_out;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endfunction

  for (genvar g = 0; g < N; g++) begin : gi
    localparam int LAT = (g == 2) ? 3 : 1;
    localparam int PRI = (g == 1) ? 1 : 0;

    ram_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(LAT), .PRIO_DATA(PRI)) dut (
      .clk(clk), .rst_n(rst_n[g]),
      .f_req(f_req[g]), .f_adr(f_adr[g]), .f_ack(f_ack[g]), .f_rdata(f_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_adr(d_adr[g]), .d_wdata(d_wdata[g]),
      .d_ack(d_ack[g]), .d_rdata(d_rdata[g]),
      .ram_read(ram_read[g]), .ram_write(ram_write[g]), .ram_adr(ram_adr[g]),
      .ram_wdata(ram_wdata[g]), .ram_out(ram_out[g]), .busy(busy[g]));

    // RAM: write on the sampling edge; read data passes LAT registers,
    // anything not a read shows DEAD so mistimed captures are visible.
    logic [15:0] mem  [256];
    logic [15:0] emem [256];
    logic [15:0] pipe [LAT];
    assign ram_out[g] = pipe[LAT-1];

    initial begin
      for (int a = 0; a < 256; a++) begin
        mem[a]  = {8'(a), ~8'(a)};
        emem[a] = {8'(a), ~8'(a)};
      end
      mem[0] = 16'hABCD; mem[1] = 16'h1234; mem[2] = 16'h2A3B; mem[3] = 16'hBEEF;
      mem[255] = 16'h0F0F;
      emem[0] = 16'hABCD; emem[1] = 16'h1234; emem[2] = 16'h2A3B; emem[3] = 16'hBEEF;
      emem[255] = 16'h0F0F;
    end

    always @(posedge clk) begin
      for (int s = LAT - 1; s > 0; s--) pipe[s] <= pipe[s-1];
      pipe[0] <= ram_read[g] ? mem[ram_adr[g]] : 16'hDEAD;
      if (ram_write[g]) mem[ram_adr[g]] <= ram_wdata[g];
    end

    // Model: a transaction is k cycles old after its grant; it lasts
    // 2 cycles for a write and 2+LAT for a read, strobe at k=1, ack at the end.
    bit          mbusy = 1'b0, mown = 1'b0, mwe = 1'b0, mlast = 1'b1;
    int          k = 0;
    logic [7:0]  madr = '0;
    logic [15:0] mwd = '0, mfr = '0, mdr = '0;
    int          dur;
    logic        g_own, e_rd, e_wr, e_done;

    assign dur    = mwe ? 2 : 2 + LAT;
    assign g_own  = (f_req[g] && d_req[g]) ? ((PRI == 1) ? 1'b1 : ~mlast) : d_req[g];
    assign e_rd   = mbusy && (k == 1) && !mwe;
    assign e_wr   = mbusy && (k == 1) && mwe;
    assign e_done = mbusy && (k == dur);

    always @(posedge clk or negedge rst_n[g]) begin
      if (!rst_n[g]) begin
        mbusy <= 1'b0; mown <= 1'b0; mwe <= 1'b0; mlast <= 1'b1; k <= 0;
        madr <= '0; mwd <= '0; mfr <= '0; mdr <= '0;
      end else if (mbusy) begin
        if (k == dur) begin
          mbusy <= 1'b0;
          mlast <= mown;
        end else begin
          if (k == 1 && mwe) emem[madr] <= mwd;
          k <= k + 1;
          if (k + 1 == dur && !mwe) begin
            if (mown) mdr <= emem[madr];
            else      mfr <= emem[madr];
          end
        end
      end else if (f_req[g] || d_req[g]) begin
        mbusy <= 1'b1;
        k     <= 1;
        mown  <= g_own;
        mwe   <= g_own & d_we[g];
        madr  <= g_own ? d_adr[g] : f_adr[g];
        mwd   <= d_wdata[g];
      end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk)
      chk($sformatf("cycle_u%0d", g),
          {3'b0, f_ack[g], d_ack[g], ram_read[g], ram_write[g], busy[g], ram_adr[g],
           f_rdata[g], d_rdata[g], ram_write[g] ? ram_wdata[g] : 16'h0},
          {3'b0, e_done && !mown, e_done && mown, e_rd, e_wr, mbusy, madr,
           mfr, mdr, e_wr ? mwd : 16'h0});
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic reset_pulse(input int i);
    rst_n[i] = 1'b0;
    tick(); tick();
    rst_n[i] = 1'b1;
  endtask

  // One request from a single port; reports ack cycle, strobe cycle/count and
  // whether ram_adr stayed on the address from cycle 2 through the ack.
  task automatic run_txn(input int i, input bit dport, input bit we,
                         input logic [7:0] adr, input logic [15:0] wd,
                         output int ack_c, output int stb_c, output int nstb,
                         output bit adr_held);
    ack_c = -1; stb_c = -1; nstb = 0; adr_held = 1'b1;
    if (dport) begin
      d_we[i] = we; d_adr[i] = adr; d_wdata[i] = wd; d_req[i] = 1'b1;
    end else begin
      f_adr[i] = adr; f_req[i] = 1'b1;
    end
    for (int c = 1; c <= 20; c++) begin
      if (ram_read[i] || ram_write[i]) begin nstb++; stb_c = c; end
      if (c >= 2 && ram_adr[i] != adr) adr_held = 1'b0;
      if (dport ? d_ack[i] : f_ack[i]) begin ack_c = c; break; end
      tick();
    end
    tick();
    if (dport) d_req[i] = 1'b0;
    else       f_req[i] = 1'b0;
  endtask

  initial begin
    int ack_c, stb_c, nstb, fa, da, nack;
    bit held;
    logic [31:0] ordv;

    tick(); tick();
    for (int i = 0; i < N; i++)
      chk($sformatf("reset_state_u%0d", i),
          {f_ack[i], d_ack[i], ram_read[i], ram_write[i], busy[i], ram_adr[i],
           f_rdata[i], d_rdata[i]}, 45'h0);
    rst_n = '1;
    tick();

    // Single fetch of address 0.
    run_txn(0, 1'b0, 1'b0, 8'h00, 16'h0, ack_c, stb_c, nstb, held);
    chk("fetch_ack_cycle", 64'(ack_c), 64'd4);
    chk("fetch_read_cycle", 64'(stb_c), 64'd2);
    chk("fetch_read_count", 64'(nstb), 64'd1);
    chk("fetch_rdata", 64'(f_rdata[0]), 64'hABCD);
    chk("fetch_d_rdata_untouched", 64'(d_rdata[0]), 64'h0);

    // Data write then read-back of address 3.
    run_txn(0, 1'b1, 1'b1, 8'h03, 16'h5A5A, ack_c, stb_c, nstb, held);
    chk("write_ack_cycle", 64'(ack_c), 64'd3);
    chk("write_strobe_cycle", 64'(stb_c), 64'd2);
    chk("write_strobe_count", 64'(nstb), 64'd1);
    chk("ram3_written", 64'(gi[0].mem[3]), 64'h5A5A);
    run_txn(0, 1'b1, 1'b0, 8'h03, 16'h0, ack_c, stb_c, nstb, held);
    chk("load_ack_cycle", 64'(ack_c), 64'd4);
    chk("load_rdata", 64'(d_rdata[0]), 64'h5A5A);
    chk("load_f_rdata_untouched", 64'(f_rdata[0]), 64'hABCD);

    // Reset in the WAIT cycle of a fetch of address 0.
    f_adr[0] = 8'h00; f_req[0] = 1'b1;
    tick(); tick();
    chk("wait_busy", 64'(busy[0]), 64'd1);
    #1 rst_n[0] = 1'b0;
    #1 chk("reset_async", {19'h0, busy[0], ram_read[0], ram_write[0], f_ack[0], d_ack[0],
                           f_rdata[0], d_rdata[0]}, 64'h0);
    tick();
    chk("reset_no_ack", 64'(f_ack[0] | d_ack[0]), 64'h0);
    rst_n[0] = 1'b1;
    run_txn(0, 1'b0, 1'b0, 8'h00, 16'h0, ack_c, stb_c, nstb, held);
    chk("reissue_ack_cycle", 64'(ack_c), 64'd4);
    chk("reissue_rdata", 64'(f_rdata[0]), 64'hABCD);

    // Both ports held continuously after reset, round-robin.
    reset_pulse(0);
    f_adr[0] = 8'h01; d_adr[0] = 8'h02; d_we[0] = 1'b0;
    f_req[0] = 1'b1; d_req[0] = 1'b1;
    ordv = '0; nack = 0;
    for (int c = 1; c <= 32; c++) begin
      if (f_ack[0] && nack < 4) begin ordv = {ordv[23:0], 8'h46}; nack++; end
      if (d_ack[0] && nack < 4) begin ordv = {ordv[23:0], 8'h44}; nack++; end
      tick();
    end
    f_req[0] = 1'b0; d_req[0] = 1'b0;
    chk("rr_order_FDFD", 64'(ordv), 64'h46444644);
    chk("rr_f_rdata", 64'(f_rdata[0]), 64'h1234);
    chk("rr_d_rdata", 64'(d_rdata[0]), 64'h2A3B);

    // Data-priority instance: fetch starves until data drops.
    f_adr[1] = 8'h01; d_adr[1] = 8'h02; d_we[1] = 1'b0;
    f_req[1] = 1'b1; d_req[1] = 1'b1;
    fa = 0; da = 0;
    for (int c = 1; c <= 24; c++) begin
      if (f_ack[1]) fa++;
      if (d_ack[1]) da++;
      tick();
    end
    d_req[1] = 1'b0;
    chk("prio_no_fetch_ack", 64'(fa), 64'd0);
    chk("prio_data_acks", 64'(da), 64'd6);
    ack_c = -1;
    for (int c = 1; c <= 10; c++) begin
      if (f_ack[1]) begin ack_c = c; break; end
      tick();
    end
    tick();
    f_req[1] = 1'b0;
    chk("prio_fetch_after_drop", 64'(ack_c), 64'd4);
    chk("prio_f_rdata", 64'(f_rdata[1]), 64'h1234);
    chk("prio_d_rdata", 64'(d_rdata[1]), 64'h2A3B);

    // RD_LAT=3 fetch of the top address.
    run_txn(2, 1'b0, 1'b0, 8'hFF, 16'h0, ack_c, stb_c, nstb, held);
    chk("lat3_ack_cycle", 64'(ack_c), 64'd6);
    chk("lat3_read_cycle", 64'(stb_c), 64'd2);
    chk("lat3_adr_held", 64'(held), 64'd1);
    chk("lat3_rdata", 64'(f_rdata[2]), 64'h0F0F);

    tick(); tick();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
